// File: rtl/ram_sync_dp_clr.sv
// ram_sync_dp_clr: synchronous dual-port RAM with a hardware clear engine.
//   Port A: CPU read/write, registered read, read-before-write.
//   Port B: read-only fetch port, registered read.
//   After reset the clear engine writes CLEAR_VAL to every word, one word per
//   cycle, while busy is high; port A writes are dropped and both read
//   registers hold 0 until the clear completes.
// Optional feature macro: RAM_BYPASS_EN
//   Defined   -> a same-address A-write/B-read collision forwards a_din to b_dout.
//   Undefined -> port B returns the old memory word on a collision.
module ram_sync_dp_clr #(
    parameter int                 ADDR_W    = 10,
    parameter int                 DATA_W    = 8,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic [DATA_W-1:0] a_dout,
    input  logic              a_cs_n,
    input  logic              a_we_n,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_dout,
    input  logic              b_cs_n,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] clr_ptr_reg;
    logic              busy_reg;
    logic [DATA_W-1:0] a_dout_reg;
    logic [DATA_W-1:0] b_dout_reg;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              run_active;
    logic              a_write;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] b_word_next;

    // Clear sequencer: walk every address once, then stay in RUN until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_CLEAR;
            clr_ptr_reg <= '0;
            busy_reg    <= 1'b1;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    clr_ptr_reg <= clr_ptr_reg + 1'b1;
                    if (clr_ptr_reg == {ADDR_W{1'b1}}) begin
                        state_reg <= ST_RUN;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_RUN;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Single write port shared by the clear engine and port A; the reset
    // cycle itself writes nothing since the clear restarts afterwards anyway.
    always_comb begin
        run_active = (state_reg == ST_RUN) && !reset;
        a_write    = run_active && !a_cs_n && !a_we_n;
        wr_en      = 1'b0;
        wr_addr    = a_addr;
        wr_data    = a_din;
        if (!reset && (state_reg == ST_CLEAR)) begin
            wr_en   = 1'b1;
            wr_addr = clr_ptr_reg;
            wr_data = CLEAR_VAL;
        end else if (a_write) begin
            wr_en   = 1'b1;
        end
    end

    // Port B read word, optionally forwarding the concurrent port A write.
    always_comb begin
`ifdef RAM_BYPASS_EN
        if (a_write && (a_addr == b_addr)) begin
            b_word_next = a_din;
        end else begin
            b_word_next = mem[b_addr];
        end
`else
        b_word_next = mem[b_addr];
`endif
    end

    // Memory array write; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read ports: old word on same-edge writes, hold when deselected,
    // forced to zero while the clear engine owns the array.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_dout_reg <= '0;
            b_dout_reg <= '0;
        end else if (state_reg == ST_CLEAR) begin
            a_dout_reg <= '0;
            b_dout_reg <= '0;
        end else begin
            if (!a_cs_n) begin
                a_dout_reg <= mem[a_addr];
            end
            if (!b_cs_n) begin
                b_dout_reg <= b_word_next;
            end
        end
    end

    assign a_dout = a_dout_reg;
    assign b_dout = b_dout_reg;
    assign busy   = busy_reg;

endmodule

// File: tb/tb_ram_sync_dp_clr.sv
// Directed testbench for ram_sync_dp_clr (ADDR_W=10, DATA_W=8, CLEAR_VAL=0).
// Build with and without +define+RAM_BYPASS_EN; the collision expectation follows.
module tb_ram_sync_dp_clr;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] CLEAR_VAL = 8'h00;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] a_addr = '0;
    logic [DATA_W-1:0] a_din = '0;
    logic [DATA_W-1:0] a_dout;
    logic              a_cs_n = 1'b1;
    logic              a_we_n = 1'b1;
    logic [ADDR_W-1:0] b_addr = '0;
    logic [DATA_W-1:0] b_dout;
    logic              b_cs_n = 1'b1;
    logic              busy;

    int checks = 0;
    int errors = 0;

    ram_sync_dp_clr #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .CLEAR_VAL (CLEAR_VAL)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .a_addr (a_addr),
        .a_din  (a_din),
        .a_dout (a_dout),
        .a_cs_n (a_cs_n),
        .a_we_n (a_we_n),
        .b_addr (b_addr),
        .b_dout (b_dout),
        .b_cs_n (b_cs_n),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports();
        a_cs_n = 1'b1;
        a_we_n = 1'b1;
        b_cs_n = 1'b1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Counts busy cycles after a reset edge; returns count (bounded).
    task automatic count_busy(output int n, output bit always_high);
        n = 0;
        always_high = 1'b1;
        while (busy === 1'b1 && n < 4 * DEPTH) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) always_high = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        bit ok;
        idle_ports();
        pulse_reset();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL reset_busy: got %b expected 1", busy);
        end
        checks++;
        if (a_dout !== 8'h00 || b_dout !== 8'h00) begin
            errors++; $display("FAIL reset_dout: got a=%h b=%h expected 00 00", a_dout, b_dout);
        end
        // Clear-time accesses: A write 0x005<=0xFF and B read 0x005.
        a_addr = 10'h005; a_din = 8'hFF; a_cs_n = 1'b0; a_we_n = 1'b0;
        b_addr = 10'h005; b_cs_n = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 4 * DEPTH) begin
            tick();
            n++;
            if (n == 10) begin
                checks++;
                if (b_dout !== 8'h00 || a_dout !== 8'h00) begin
                    errors++; $display("FAIL clear_dout: got a=%h b=%h expected 00 00", a_dout, b_dout);
                end
            end
            if (n == 1000) idle_ports();
        end
        checks++;
        if (n != DEPTH) begin
            errors++; $display("FAIL clear_len: got %0d cycles expected %0d", n, DEPTH);
        end
        $display("reset: busy for %0d cycles", n);
        // Read every word on port B.
        b_cs_n = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            b_addr = i[ADDR_W-1:0];
            tick();
            checks++;
            if (b_dout !== CLEAR_VAL) begin
                errors++; ok = 1'b0;
                $display("FAIL clear_word: addr %h got %h expected %h", i, b_dout, CLEAR_VAL);
            end
        end
        b_cs_n = 1'b1;
        $display("reset: swept %0d words on port B", DEPTH);
        // The write dropped during the clear must not have landed.
        b_addr = 10'h005; b_cs_n = 1'b0;
        tick();
        b_cs_n = 1'b1;
        checks++;
        if (b_dout !== CLEAR_VAL) begin
            errors++; $display("FAIL clear_drop_write: got %h expected %h", b_dout, CLEAR_VAL);
        end
        $display("clear-time write: B[005]=%h", b_dout);
    endtask

    task automatic test_restart();
        int n;
        bit fell;
        idle_ports();
        pulse_reset();
        for (int i = 0; i < 'h155; i++) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL restart_busy_pre: got %b expected 1", busy);
        end
        pulse_reset();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL restart_busy_post: got %b expected 1", busy);
        end
        count_busy(n, fell);
        checks++;
        if (n != DEPTH || !fell) begin
            errors++; $display("FAIL restart_len: got %0d cycles expected %0d", n, DEPTH);
        end
        $display("restart: busy for %0d cycles after second reset", n);
    endtask

    task automatic test_port_a();
        idle_ports();
        a_addr = 10'h3FF; a_din = 8'hA5; a_cs_n = 1'b0; a_we_n = 1'b0;
        tick();
        checks++;
        if (a_dout !== CLEAR_VAL) begin
            errors++; $display("FAIL a_write_old: got %h expected %h", a_dout, CLEAR_VAL);
        end
        a_we_n = 1'b1;
        tick();
        checks++;
        if (a_dout !== 8'hA5) begin
            errors++; $display("FAIL a_read: got %h expected a5", a_dout);
        end
        a_cs_n = 1'b1; a_addr = 10'h000;
        tick();
        checks++;
        if (a_dout !== 8'hA5) begin
            errors++; $display("FAIL a_hold: got %h expected a5", a_dout);
        end
        $display("port A: write/read 3ff -> %h", a_dout);
    endtask

    task automatic test_read_before_write();
        idle_ports();
        a_addr = 10'h010; a_din = 8'h5A; a_cs_n = 1'b0; a_we_n = 1'b0;
        tick();
        a_din = 8'hC3;
        tick();
        checks++;
        if (a_dout !== 8'h5A) begin
            errors++; $display("FAIL a_rbw: got %h expected 5a", a_dout);
        end
        a_we_n = 1'b1;
        tick();
        a_cs_n = 1'b1;
        checks++;
        if (a_dout !== 8'hC3) begin
            errors++; $display("FAIL a_rbw_new: got %h expected c3", a_dout);
        end
        $display("port A: read-before-write 010 new=%h", a_dout);
    endtask

    task automatic test_collision();
        logic [DATA_W-1:0] exp_b;
`ifdef RAM_BYPASS_EN
        exp_b = 8'h77;
`else
        exp_b = 8'h11;
`endif
        idle_ports();
        a_addr = 10'h020; a_din = 8'h11; a_cs_n = 1'b0; a_we_n = 1'b0;
        tick();
        a_din = 8'h77;
        b_addr = 10'h020; b_cs_n = 1'b0;
        tick();
        idle_ports();
        checks++;
        if (b_dout !== exp_b) begin
            errors++; $display("FAIL collision_b: got %h expected %h", b_dout, exp_b);
        end
        checks++;
        if (a_dout !== 8'h11) begin
            errors++; $display("FAIL collision_a: got %h expected 11", a_dout);
        end
        $display("collision: b_dout=%h a_dout=%h", b_dout, a_dout);
        b_cs_n = 1'b0;
        tick();
        checks++;
        if (b_dout !== 8'h77) begin
            errors++; $display("FAIL collision_after: got %h expected 77", b_dout);
        end
        b_cs_n = 1'b1; b_addr = 10'h3FF;
        tick();
        checks++;
        if (b_dout !== 8'h77) begin
            errors++; $display("FAIL b_hold: got %h expected 77", b_dout);
        end
        $display("port B: hold b_dout=%h", b_dout);
    endtask

    task automatic test_reset_in_run();
        int n;
        bit fell;
        idle_ports();
        pulse_reset();
        checks++;
        if (busy !== 1'b1 || a_dout !== 8'h00 || b_dout !== 8'h00) begin
            errors++; $display("FAIL run_reset: got busy=%b a=%h b=%h expected 1 00 00", busy, a_dout, b_dout);
        end
        count_busy(n, fell);
        checks++;
        if (n != DEPTH || !fell) begin
            errors++; $display("FAIL run_reset_len: got %0d expected %0d", n, DEPTH);
        end
        b_addr = 10'h3FF; b_cs_n = 1'b0;
        tick();
        b_cs_n = 1'b1;
        checks++;
        if (b_dout !== CLEAR_VAL) begin
            errors++; $display("FAIL run_reset_cleared: got %h expected %h", b_dout, CLEAR_VAL);
        end
        $display("reset in RUN: %0d clear cycles, B[3ff]=%h", n, b_dout);
    endtask

    initial begin
        test_reset();
        test_restart();
        test_port_a();
        test_read_before_write();
        test_collision();
        test_reset_in_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
